// File: rtl/pwm_pkg.sv
// Shared constants for the PWM/timer configuration sequencer.
// Register map, ctrl bit positions, FSM encodings and reset defaults.
package pwm_pkg;

   localparam logic [3:0] ADR_CTRL = 4'd0;
   localparam logic [3:0] ADR_DIV  = 4'd1;
   localparam logic [3:0] ADR_PER  = 4'd2;
   localparam logic [3:0] ADR_DC   = 4'd3;

   localparam int CTRL_EN  = 2;
   localparam int CTRL_IRQ = 5;
   localparam int CTRL_RST = 7;

   localparam logic [15:0] PER_RST = 16'h03E8;
   localparam logic [15:0] DC_RST  = 16'h0000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_WR,
      ST_DONE,
      ST_FAIL
   } seq_state_e;

   typedef enum logic [1:0] {
      WP_IDLE,
      WP_WR,
      WP_WAIT_ACK,
      WP_GAP
   } wp_state_e;

   typedef enum logic [1:0] {
      OP_START,
      OP_DC,
      OP_STOP
   } op_e;

endpackage

// File: rtl/pwm_wb_write_port.sv
// Single Wishbone write engine: WR, WAIT_ACK, GAP with ack timeout.
// o_done marks the GAP cycle so a following request chains with no bubble.
module pwm_wb_write_port
   import pwm_pkg::*;
#(
   parameter int TIMEOUT_CYC = 16,
   parameter int DW          = 16
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_req,
   input  logic [3:0]    i_adr,
   input  logic [DW-1:0] i_data,
   input  logic          i_wb_ack,
   output logic          o_wb_cyc,
   output logic          o_wb_stb,
   output logic          o_wb_we,
   output logic [3:0]    o_wb_adr,
   output logic [DW-1:0] o_wb_data,
   output logic          o_done,
   output logic          o_timeout
);

   localparam int CW = $clog2(TIMEOUT_CYC);

   wp_state_e     st_q;
   logic [CW-1:0] cnt_q;
   logic          last_wait;

   assign last_wait = (cnt_q == CW'(TIMEOUT_CYC - 1));
   assign o_done    = (st_q == WP_GAP);
   assign o_timeout = (st_q == WP_WAIT_ACK) && !i_wb_ack && last_wait;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         st_q      <= WP_IDLE;
         cnt_q     <= '0;
         o_wb_cyc  <= 1'b0;
         o_wb_stb  <= 1'b0;
         o_wb_we   <= 1'b0;
         o_wb_adr  <= '0;
         o_wb_data <= '0;
      end else begin
         unique case (st_q)
            WP_IDLE, WP_GAP: begin
               if (i_req) begin
                  st_q      <= WP_WR;
                  o_wb_cyc  <= 1'b1;
                  o_wb_stb  <= 1'b1;
                  o_wb_we   <= 1'b1;
                  o_wb_adr  <= i_adr;
                  o_wb_data <= i_data;
               end else begin
                  st_q <= WP_IDLE;
               end
            end
            WP_WR: begin
               st_q  <= WP_WAIT_ACK;
               cnt_q <= '0;
            end
            WP_WAIT_ACK: begin
               if (i_wb_ack || last_wait) begin
                  st_q     <= i_wb_ack ? WP_GAP : WP_IDLE;
                  o_wb_cyc <= 1'b0;
                  o_wb_stb <= 1'b0;
                  o_wb_we  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: st_q <= WP_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/pwm_cfg_sequencer.sv
// Request FSM for the PWM timer: validates requests and walks the
// register write list through the single-write engine.
module pwm_cfg_sequencer
   import pwm_pkg::*;
#(
   parameter int TIMEOUT_CYC = 16,
   parameter int DW          = 16
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_start,
   input  logic          i_dc_upd,
   input  logic          i_stop,
   input  logic [7:0]    i_cfg_ctrl,
   input  logic [DW-1:0] i_cfg_div,
   input  logic [DW-1:0] i_cfg_period,
   input  logic [DW-1:0] i_cfg_dc,
   output logic          o_wb_cyc,
   output logic          o_wb_stb,
   output logic          o_wb_we,
   output logic [3:0]    o_wb_adr,
   output logic [DW-1:0] o_wb_data,
   input  logic          i_wb_ack,
   output logic          o_busy,
   output logic          o_done,
   output logic          o_err
);

   seq_state_e    st_q;
   op_e           op_q;
   logic [2:0]    idx_q, last_q, req_idx;
   logic [7:0]    ctrl_q;
   logic [DW-1:0] div_q, per_q, dc_q, per_lat_q;
   logic          reject, wp_req, wp_done, wp_timeout;
   logic [3:0]    wr_adr;
   logic [DW-1:0] wr_data;

   always_comb begin
      reject = 1'b0;
      case (op_q)
         OP_START: reject = (div_q == '0) || (dc_q > per_q);
         OP_DC:    reject = (dc_q > per_lat_q);
         default:  reject = 1'b0;
      endcase
   end

   // Index 0 and 4 both target ctrl: stop first, final image last.
   assign req_idx = (st_q == ST_CHECK) ? idx_q : idx_q + 3'd1;
   assign wp_req  = ((st_q == ST_CHECK) && !reject) ||
                    ((st_q == ST_WR) && wp_done && (idx_q != last_q));

   always_comb begin
      wr_adr  = ADR_CTRL;
      wr_data = '0;
      case (req_idx)
         3'd1: begin wr_adr = ADR_DIV; wr_data = div_q; end
         3'd2: begin wr_adr = ADR_PER; wr_data = per_q; end
         3'd3: begin wr_adr = ADR_DC;  wr_data = dc_q;  end
         3'd4: begin
            wr_data[7:0]     = ctrl_q;
            wr_data[CTRL_IRQ] = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         st_q      <= ST_IDLE;
         op_q      <= OP_STOP;
         idx_q     <= '0;
         last_q    <= '0;
         ctrl_q    <= '0;
         div_q     <= '0;
         per_q     <= DW'(PER_RST);
         dc_q      <= DW'(DC_RST);
         per_lat_q <= DW'(PER_RST);
         o_busy    <= 1'b0;
         o_done    <= 1'b0;
         o_err     <= 1'b0;
      end else begin
         o_done <= 1'b0;
         unique case (st_q)
            ST_IDLE: begin
               if (i_stop || i_start || i_dc_upd) begin
                  st_q   <= ST_CHECK;
                  o_busy <= 1'b1;
                  o_err  <= 1'b0;
                  ctrl_q <= i_cfg_ctrl;
                  div_q  <= i_cfg_div;
                  per_q  <= i_cfg_period;
                  dc_q   <= i_cfg_dc;
                  if (i_stop) begin
                     op_q <= OP_STOP;  idx_q <= 3'd0; last_q <= 3'd0;
                  end else if (i_start) begin
                     op_q <= OP_START; idx_q <= 3'd0; last_q <= 3'd4;
                  end else begin
                     op_q <= OP_DC;    idx_q <= 3'd3; last_q <= 3'd3;
                  end
               end
            end
            ST_CHECK: begin
               if (reject) begin
                  st_q  <= ST_FAIL;
                  o_err <= 1'b1;
               end else begin
                  st_q <= ST_WR;
               end
            end
            ST_WR: begin
               if (wp_timeout) begin
                  st_q  <= ST_FAIL;
                  o_err <= 1'b1;
               end else if (wp_done) begin
                  if (idx_q == last_q) begin
                     st_q   <= ST_DONE;
                     o_done <= 1'b1;
                     if (op_q == OP_START) per_lat_q <= per_q;
                  end else begin
                     idx_q <= idx_q + 3'd1;
                  end
               end
            end
            ST_DONE, ST_FAIL: begin
               st_q   <= ST_IDLE;
               o_busy <= 1'b0;
            end
            default: st_q <= ST_IDLE;
         endcase
      end
   end

   pwm_wb_write_port #(
      .TIMEOUT_CYC(TIMEOUT_CYC),
      .DW         (DW)
   ) u_wp (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_req    (wp_req),
      .i_adr    (wr_adr),
      .i_data   (wr_data),
      .i_wb_ack (i_wb_ack),
      .o_wb_cyc (o_wb_cyc),
      .o_wb_stb (o_wb_stb),
      .o_wb_we  (o_wb_we),
      .o_wb_adr (o_wb_adr),
      .o_wb_data(o_wb_data),
      .o_done   (wp_done),
      .o_timeout(wp_timeout)
   );

endmodule
